seq_pattern_gen: RTL and testbench

Serial bit-pattern transmitter: the source side of the single-bit `w` stream consumed by the sequence-detector family. On a `start` request it latches a pattern, a length, a repeat count and an inter-frame gap. It then drives the pattern MSB-first on `w`, one bit per clock, with a `valid` qualifier. It serves as a synthesizable stimulus source in detector benches and as a frame emitter on-chip.

---
 rtl/seq_gen_pkg.sv | 15 +
 rtl/seq_gen_shifter.sv | 68 ++++++
 rtl/seq_pattern_gen.sv | 206 ++++++++++++++++++++
 tb/tb_seq_pattern_gen.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_gen_pkg.sv
// Shared types and default sizes for the serial pattern generator.
// Optional parity cycle is selected by defining SEQ_GEN_PARITY_EN.
package seq_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } seq_gen_state_t;

    localparam int SEQ_GEN_PAT_W_DEF = 8;
    localparam int SEQ_GEN_CNT_W_DEF = 4;

endpackage

// File: rtl/seq_gen_shifter.sv
// Left-aligned pattern shifter with a remaining-bit counter for seq_pattern_gen.
// With SEQ_GEN_PARITY_EN defined it also holds the even parity of the loaded bits.
module seq_gen_shifter
    import seq_gen_pkg::*;
#(
    parameter int PAT_W = SEQ_GEN_PAT_W_DEF,
    parameter int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [PAT_W-1:0] i_pattern,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_msb_next,
`ifdef SEQ_GEN_PARITY_EN
    output logic             o_par_next,
`endif
    output logic             o_last
);

    localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);

    logic [PAT_W-1:0] r_shift;
    logic [LEN_W-1:0] r_bits;
    logic [LEN_W-1:0] w_sh_amt;
    logic [PAT_W-1:0] w_aligned;

    assign w_sh_amt  = PAT_W_L - i_len;
    assign w_aligned = i_pattern << w_sh_amt;

    // Registered outputs in the top need the MSB as it will be after this edge.
    assign o_msb_next = i_load  ? w_aligned[PAT_W-1] :
                        i_shift ? r_shift[PAT_W-2]   : r_shift[PAT_W-1];
    assign o_last     = (r_bits == LEN_W'(1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_shift <= '0;
            r_bits  <= '0;
        end else if (i_load) begin
            r_shift <= w_aligned;
            r_bits  <= i_len;
        end else if (i_shift) begin
            r_shift <= {r_shift[PAT_W-2:0], 1'b0};
            r_bits  <= r_bits - LEN_W'(1);
        end
    end

`ifdef SEQ_GEN_PARITY_EN
    logic             r_par;
    logic [PAT_W-1:0] w_mask;
    logic             w_par_load;

    assign w_mask     = ~({PAT_W{1'b1}} << i_len);
    assign w_par_load = ^(i_pattern & w_mask);
    assign o_par_next = i_load ? w_par_load : r_par;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_par <= 1'b0;
        end else if (i_load) begin
            r_par <= w_par_load;
        end
    end
`endif

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial bit-pattern transmitter: MSB-first frames on w with valid, repeats and gaps.
// Define SEQ_GEN_PARITY_EN to append an even-parity bit after every frame.
module seq_pattern_gen
    import seq_gen_pkg::*;
#(
    parameter int PAT_W = SEQ_GEN_PAT_W_DEF,
    parameter int CNT_W = SEQ_GEN_CNT_W_DEF,
    parameter int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic [CNT_W-1:0] gap,
    output logic             w,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);

    seq_gen_state_t   r_state;
    seq_gen_state_t   w_state_next;
    logic [PAT_W-1:0] r_pat;
    logic [LEN_W-1:0] r_len;
    logic [CNT_W-1:0] r_frames;
    logic [CNT_W-1:0] r_gap_cfg;
    logic [CNT_W-1:0] r_gap_cnt;
    logic             r_w;
    logic             r_valid;
    logic             r_busy;
    logic             r_done;

    logic [LEN_W-1:0] w_len_clamped;
    logic [PAT_W-1:0] w_sh_pat;
    logic [LEN_W-1:0] w_sh_len;
    logic             w_accept;
    logic             w_load;
    logic             w_shift;
    logic             w_frames_dec;
    logic             w_gap_load;
    logic             w_gap_dec;
    logic             w_frame_end;
    logic             w_last;
    logic             w_msb_next;
    logic             w_bit_next;

    assign w_len_clamped = (len > PAT_W_L) ? PAT_W_L : len;
    // The accept edge loads straight from the inputs; reloads use the latched copy.
    assign w_sh_pat      = w_accept ? pattern       : r_pat;
    assign w_sh_len      = w_accept ? w_len_clamped : r_len;

`ifdef SEQ_GEN_PARITY_EN
    logic r_par_phase;
    logic w_par_phase_next;
    logic w_par_next;

    assign w_frame_end = r_par_phase;
    assign w_bit_next  = w_par_phase_next ? w_par_next : w_msb_next;
`else
    assign w_frame_end = w_last;
    assign w_bit_next  = w_msb_next;
`endif

    seq_gen_shifter #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_shifter (
        .clk        (clk),
        .resetn     (resetn),
        .i_load     (w_load),
        .i_shift    (w_shift),
        .i_pattern  (w_sh_pat),
        .i_len      (w_sh_len),
        .o_msb_next (w_msb_next),
`ifdef SEQ_GEN_PARITY_EN
        .o_par_next (w_par_next),
`endif
        .o_last     (w_last)
    );

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_frames_dec = 1'b0;
        w_gap_load   = 1'b0;
        w_gap_dec    = 1'b0;
`ifdef SEQ_GEN_PARITY_EN
        w_par_phase_next = r_par_phase;
`endif
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_load   = 1'b1;
`ifdef SEQ_GEN_PARITY_EN
                    w_par_phase_next = 1'b0;
`endif
                    w_state_next = (w_len_clamped == '0) ? DONE : SEND;
                end
            end
            SEND: begin
                w_shift = 1'b1;
`ifdef SEQ_GEN_PARITY_EN
                if (r_par_phase) begin
                    w_shift = 1'b0;
                end else if (w_last) begin
                    w_par_phase_next = 1'b1;
                end
`endif
                if (w_frame_end) begin
`ifdef SEQ_GEN_PARITY_EN
                    w_par_phase_next = 1'b0;
`endif
                    if (r_frames != '0) begin
                        w_frames_dec = 1'b1;
                        if (r_gap_cfg != '0) begin
                            w_state_next = GAP;
                            w_gap_load   = 1'b1;
                        end else begin
                            w_load = 1'b1;
                        end
                    end else begin
                        w_state_next = DONE;
                    end
                end
            end
            GAP: begin
                if (r_gap_cnt == CNT_W'(1)) begin
                    w_load       = 1'b1;
                    w_state_next = SEND;
                end else begin
                    w_gap_dec = 1'b1;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= IDLE;
            r_pat     <= '0;
            r_len     <= '0;
            r_frames  <= '0;
            r_gap_cfg <= '0;
            r_gap_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_pat     <= pattern;
                r_len     <= w_len_clamped;
                r_frames  <= repeat_cnt;
                r_gap_cfg <= gap;
            end else if (w_frames_dec) begin
                r_frames <= r_frames - CNT_W'(1);
            end
            if (w_gap_load) begin
                r_gap_cnt <= r_gap_cfg;
            end else if (w_gap_dec) begin
                r_gap_cnt <= r_gap_cnt - CNT_W'(1);
            end
        end
    end

`ifdef SEQ_GEN_PARITY_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_par_phase <= 1'b0;
        end else begin
            r_par_phase <= w_par_phase_next;
        end
    end
`endif

    // Outputs are flops fed from next-state values so they line up with the state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_w     <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_w     <= (w_state_next == SEND) & w_bit_next;
            r_valid <= (w_state_next == SEND);
            r_busy  <= (w_state_next != IDLE);
            r_done  <= (w_state_next == DONE);
        end
    end

    assign w     = r_w;
    assign valid = r_valid;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Scoreboard bench for seq_pattern_gen: expected per-busy-cycle symbols are queued
// by the stimulus ('1'/'0' = valid bit, '-' = gap cycle, 'D' = done cycle).
module tb_seq_pattern_gen;

    logic       clk;
    logic       resetn;
    logic       start;
    logic [7:0] pattern;
    logic [3:0] len;
    logic [3:0] repeat_cnt;
    logic [3:0] gap;
    logic       w;
    logic       valid;
    logic       busy;
    logic       done;

    int  n_cmp;
    int  n_bad;
    byte exp_q[$];

    seq_pattern_gen dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .pattern    (pattern),
        .len        (len),
        .repeat_cnt (repeat_cnt),
        .gap        (gap),
        .w          (w),
        .valid      (valid),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every busy cycle consumes one expected symbol.
    always @(negedge clk) begin
        byte  c;
        logic ev, ew, ed;
        if (resetn) begin
            n_cmp++;
            if (busy) begin
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL busy_unexpected: busy=1 valid=%0b w=%0b done=%0b, required no busy cycle",
                             valid, w, done);
                end else begin
                    c  = exp_q.pop_front();
                    ev = (c == "0") || (c == "1");
                    ew = (c == "1");
                    ed = (c == "D");
                    if ({valid, w, done} !== {ev, ew, ed}) begin
                        n_bad++;
                        $display("FAIL stream_symbol '%s': got valid=%0b w=%0b done=%0b, required valid=%0b w=%0b done=%0b",
                                 c, valid, w, done, ev, ew, ed);
                    end
                end
            end else if ({valid, w, done} !== 3'b000) begin
                n_bad++;
                $display("FAIL idle_outputs: got valid=%0b w=%0b done=%0b, required 000", valid, w, done);
            end
        end
    end

    task automatic push_exp(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (busy && k < 300) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (k >= 300) $display("FAIL %s_timeout: busy still %0b after %0d cycles, required 0", name, busy, k);
        check({name, "_leftover"}, exp_q.size(), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
    endtask

    task automatic run_frame(input string name, input logic [7:0] p, input logic [3:0] l,
                             input logic [3:0] r, input logic [3:0] g, input string exp);
        @(posedge clk);
        #1;
        pattern    = p;
        len        = l;
        repeat_cnt = r;
        gap        = g;
        start      = 1'b1;
        push_exp(exp);
        @(posedge clk);
        #1;
        start = 1'b0;
        drain(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        n_cmp      = 0;
        n_bad      = 0;
        resetn     = 1'b0;
        start      = 1'b0;
        pattern    = '0;
        len        = '0;
        repeat_cnt = '0;
        gap        = '0;
        #3;
        check("reset_outputs", {valid, w, busy, done}, 4'b0000);
        #19 resetn = 1'b1;
        repeat (2) @(posedge clk);

`ifdef SEQ_GEN_PARITY_EN
        run_frame("single",    8'b0000_1011, 4'd4, 4'd0, 4'd0, "10111D");
        run_frame("rep_gap",   8'b0000_0011, 4'd2, 4'd2, 4'd3, "110---110---110D");
        run_frame("len_zero",  8'b1010_1010, 4'd0, 4'd0, 4'd0, "D");
        run_frame("len_clamp", 8'b1010_0110, 4'd9, 4'd0, 4'd0, "101001100D");
        run_frame("b2b",       8'b0000_0110, 4'd3, 4'd1, 4'd0, "11001100D");
        run_frame("full_gap1", 8'b1100_1010, 4'd8, 4'd1, 4'd1, "110010100-110010100D");
`else
        run_frame("single",    8'b0000_1011, 4'd4, 4'd0, 4'd0, "1011D");
        run_frame("rep_gap",   8'b0000_0011, 4'd2, 4'd2, 4'd3, "11---11---11D");
        run_frame("len_zero",  8'b1010_1010, 4'd0, 4'd0, 4'd0, "D");
        run_frame("len_clamp", 8'b1010_0110, 4'd9, 4'd0, 4'd0, "10100110D");
        run_frame("b2b",       8'b0000_0110, 4'd3, 4'd1, 4'd0, "110110D");
        run_frame("full_gap1", 8'b1100_1010, 4'd8, 4'd1, 4'd1, "11001010-11001010D");
`endif

        // start and new inputs mid-frame must not disturb the frame in flight
        @(posedge clk);
        #1;
        pattern = 8'b0000_1011; len = 4'd4; repeat_cnt = 4'd0; gap = 4'd0; start = 1'b1;
`ifdef SEQ_GEN_PARITY_EN
        push_exp("10111D");
`else
        push_exp("1011D");
`endif
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b1; pattern = 8'hF0; len = 4'd7; repeat_cnt = 4'd3; gap = 4'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        drain("ignored_start");
        repeat (4) @(posedge clk);

        // start held high re-triggers after the DONE cycle
        @(posedge clk);
        #1;
        pattern = 8'b0000_1011; len = 4'd4; repeat_cnt = 4'd0; gap = 4'd0; start = 1'b1;
`ifdef SEQ_GEN_PARITY_EN
        push_exp("10111D10111D");
`else
        push_exp("1011D1011D");
`endif
        k = 0;
        while (!done && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("held_start_done_seen", {31'd0, done}, 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        start = 1'b0;
        drain("held_start");

        // reset during bit 2 of a 4-bit frame, then a clean full frame
        @(posedge clk);
        #1;
        pattern = 8'b0000_1011; len = 4'd4; repeat_cnt = 4'd0; gap = 4'd0; start = 1'b1;
        push_exp("1011D");
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("rst_mid_w", {31'd0, w}, 32'd0);
        check("rst_mid_valid", {31'd0, valid}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3;
        resetn = 1'b1;
        repeat (2) @(posedge clk);
        check("post_reset_idle", {valid, w, busy, done}, 4'b0000);
`ifdef SEQ_GEN_PARITY_EN
        run_frame("after_reset", 8'b0000_1011, 4'd4, 4'd0, 4'd0, "10111D");
`else
        run_frame("after_reset", 8'b0000_1011, 4'd4, 4'd0, 4'd0, "1011D");
`endif

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
